// File: rtl/multicycle_core.sv
// Multi-cycle RV32I subset core with one unified req/ready memory port.
// Optional perf counters: define MULTICYCLE_CORE_PERF_CNT_EN.
module multicycle_core #(
   parameter int          NREGS    = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc_out,
   output logic              trap
`ifdef MULTICYCLE_CORE_PERF_CNT_EN
   ,
   output logic [63:0]       cycle_cnt,
   output logic [63:0]       instret_cnt
`endif
);

   localparam int RW = (NREGS == 16) ? 4 : 5;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_e;

   state_e state_q, state_d;

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] old_pc_q, old_pc_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];

   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [4:0] rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b;

   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                   ir_q[30:25], ir_q[11:8], 1'b0};

   logic is_r, is_addi, is_lw, is_sw, is_beq;
   logic idx_bad, illegal;

   always_comb begin
      is_r    = (opc == 7'b0110011) &&
                (((f7 == 7'b0000000) &&
                  (f3 == 3'b000 || f3 == 3'b010 ||
                   f3 == 3'b110 || f3 == 3'b111)) ||
                 ((f7 == 7'b0100000) && (f3 == 3'b000)));
      is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
      is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
      is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
      is_beq  = (opc == 7'b1100011) && (f3 == 3'b000);
      // Only the index fields a format actually uses are range-checked.
      idx_bad = (NREGS == 16) && (
         (is_r && (rd[4] || rs1[4] || rs2[4])) ||
         ((is_addi || is_lw) && (rd[4] || rs1[4])) ||
         ((is_sw || is_beq) && (rs1[4] || rs2[4])));
      illegal = !(is_r || is_addi || is_lw || is_sw || is_beq)
                || idx_bad;
   end

   logic [31:0] op_a, op_b, alu_res;
   logic op_sub, op_and, op_or, op_slt, br_eq;

   always_comb begin
      op_a   = is_beq ? old_pc_q : a_q;
      op_b   = is_r ? b_q : imm_q;
      op_sub = is_r && (f3 == 3'b000) && f7[5];
      op_and = is_r && (f3 == 3'b111);
      op_or  = is_r && (f3 == 3'b110);
      op_slt = is_r && (f3 == 3'b010);
      br_eq  = (a_q == b_q);
      unique case (1'b1)
         op_sub:  alu_res = op_a - op_b;
         op_and:  alu_res = op_a & op_b;
         op_or:   alu_res = op_a | op_b;
         op_slt:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         default: alu_res = op_a + op_b;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         old_pc_q <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         old_pc_q <= old_pc_d;
         alu_q    <= alu_d;
         mdr_q    <= mdr_d;
         regs_q   <= regs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
         S_EXEC: begin
            unique case (1'b1)
               is_beq:
                  state_d = (br_eq && alu_res[1:0] != 2'b00)
                            ? S_TRAP : S_FETCH;
               is_lw, is_sw:
                  state_d = (alu_res[1:0] != 2'b00) ? S_TRAP : S_MEM;
               default: state_d = S_WB;
            endcase
         end
         S_MEM:   if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
         S_WB:    state_d = S_FETCH;
         default: state_d = S_TRAP;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      old_pc_d = old_pc_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      regs_d   = regs_q;
      unique case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d = mem_rdata;
               pc_d = pc_q + 32'd4;
            end
         end
         S_DECODE: begin
            a_d      = regs_q[rs1[RW-1:0]];
            b_d      = regs_q[rs2[RW-1:0]];
            old_pc_d = pc_q - 32'd4;
            unique case (1'b1)
               is_sw:   imm_d = imm_s;
               is_beq:  imm_d = imm_b;
               default: imm_d = imm_i;
            endcase
         end
         S_EXEC: begin
            alu_d = alu_res;
            if (is_beq && br_eq && alu_res[1:0] == 2'b00)
               pc_d = alu_res;
         end
         S_MEM: begin
            if (mem_ready && !is_sw) mdr_d = mem_rdata;
         end
         S_WB: begin
            if (rd != 5'd0)
               regs_d[rd[RW-1:0]] = is_lw ? mdr_q : alu_q;
         end
         default: ;
      endcase
   end

   logic              req_c, we_c;
   logic [ADDR_W-1:0] addr_c;
   logic [31:0]       wdata_c;

   always_comb begin
      req_c   = 1'b0;
      we_c    = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
      trap    = (state_q == S_TRAP);
      unique case (state_q)
         S_FETCH: begin
            req_c  = 1'b1;
            addr_c = pc_q[ADDR_W-1:0];
         end
         S_MEM: begin
            req_c   = 1'b1;
            we_c    = is_sw;
            addr_c  = alu_q[ADDR_W-1:0];
            wdata_c = b_q;
         end
         default: ;
      endcase
   end

   // Gated by reset so the bus idles the instant reset asserts.
   assign mem_req   = req_c & reset;
   assign mem_we    = we_c & reset;
   assign mem_addr  = reset ? addr_c : '0;
   assign mem_wdata = reset ? wdata_c : '0;
   assign pc_out    = pc_q;

`ifdef MULTICYCLE_CORE_PERF_CNT_EN
   logic [63:0] cycle_cnt_q, cycle_cnt_d;
   logic [63:0] instret_cnt_q, instret_cnt_d;
   logic        retire;

   always_comb begin
      retire = (state_d == S_FETCH) &&
               (state_q == S_WB || state_q == S_EXEC ||
                state_q == S_MEM);
      cycle_cnt_d   = (state_q == S_TRAP) ? cycle_cnt_q
                                          : cycle_cnt_q + 64'd1;
      instret_cnt_d = retire ? instret_cnt_q + 64'd1 : instret_cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule
